usb_frame_serializer: RTL and testbench
=======================================

// Module: usb_frame_serializer
// PURPOSE
// - Downstream consumer of the ULPI capture block's INFO and DATA FIFOs, in the clk_ice domain.
// - Pops one 16-bit INFO word {RxCMD[5:0], LEN[9:0]}, then pops LEN payload bytes.
// - Emits each captured USB packet as a framed byte stream toward the UART TX stage.
// - Frame = SYNC, HDR0 = {RxCMD[5:0], LEN[9:8]}, HDR1 = LEN[7:0], LEN payload bytes, [CSUM].
// PARAMETERS
// SYNC_BYTE   8'hA5   first byte of every frame
// MAX_LEN     10'd1023  payload bytes sent = min(LEN, MAX_LEN); HDR carries the clamped value
// PORTS
// clk_ice          in   1   system clock (12 MHz)
// rst              in   1   reset, asynchronous, active-high
// INFO_buff_empty  in   1   INFO FIFO empty
// USB_INFO_DATA    in   16  INFO FIFO read data, valid the cycle after INFO_re
// INFO_re          out  1   INFO FIFO pop, 1-cycle pulse
// DATA_buff_empty  in   1   DATA FIFO empty
// USB_DATA         in   8   DATA FIFO read data, valid the cycle after DATA_re
// DATA_re          out  1   DATA FIFO pop, 1-cycle pulse
// TX_DATA          out  8   byte to UART TX
// TX_VALID         out  1   TX_DATA valid
// TX_READY         in   1   UART accepts byte when TX_VALID & TX_READY on a clk_ice edge
// BUSY             out  1   high in every state except IDLE
// BEHAVIOUR
// - Reset values: INFO_re=0, DATA_re=0, TX_VALID=0, TX_DATA=8'h00, BUSY=0, state=IDLE, counters=0.
// - FSM states: IDLE, INFO_WAIT, SYNC, HDR0, HDR1, DATA_RD, DATA_WAIT, DATA_TX, CSUM.
// - IDLE: if !INFO_buff_empty, pulse INFO_re for one cycle, then go to INFO_WAIT.
// - INFO_WAIT: latch RxCMD and LEN' = min(LEN, MAX_LEN), clear the remaining counter, then go to SYNC.
// - SYNC/HDR0/HDR1/CSUM/DATA_TX: drive TX_DATA and assert TX_VALID; hold both stable until TX_READY.
//   - Advance on the handshake edge. TX_VALID stays high back-to-back when the next byte is ready.
// - HDR1 done: if LEN'=0, go to CSUM (macro on) or IDLE (macro off); otherwise go to DATA_RD.
// - DATA_RD: if DATA_buff_empty, stall (DATA_re=0, TX_VALID=0).
//   - Otherwise pulse DATA_re, go to DATA_WAIT, then DATA_TX with USB_DATA registered into TX_DATA.
// - After each payload handshake: decrement the remaining count. At 0, go to CSUM or IDLE; otherwise go to DATA_RD.
// - No DATA prefetch: at most one outstanding DATA_re. Never pop INFO while BUSY.
// - Latency: INFO_re is asserted 1 cycle after INFO_buff_empty falls in IDLE.
//   - With TX_READY=1, SYNC is valid 2 cycles after INFO_re.
// - LEN > MAX_LEN: excess bytes are not popped; they are left for the integrator to flush.
// - rst asserted mid-frame: immediate return to IDLE with all outputs at reset values.
//   - A partial frame is abandoned; the receiver resyncs on SYNC_BYTE.
// - TX_READY high while TX_VALID low: ignored.
// CONFIGURATION
// - USB_FRAME_CSUM_EN defined: after the last payload byte (or HDR1 when LEN'=0), send CSUM.
//   - CSUM = XOR of HDR0, HDR1 and all payload bytes. SYNC is excluded.
// - USB_FRAME_CSUM_EN undefined: no CSUM state, no XOR register; the frame ends after the last payload byte.
// TESTING
// - T1: INFO=16'b101101_0000000011, DATA=A4,3F,03, TX_READY=1, macro on.
//   - Stream A5,B4,03,A4,3F,03,2F. Exactly 1 INFO_re and 3 DATA_re.
// - T2: INFO=16'b100101_0000000000, macro off.
//   - Stream A5,94,00. No DATA_re. BUSY drops after the HDR1 handshake.
// - T3: T1 with TX_READY toggling 1-of-3 cycles.
//   - Identical byte stream. TX_DATA stable while TX_VALID & !TX_READY.
// - T4: LEN=3 but DATA FIFO empty after the first byte for 10 cycles.
//   - FSM stalls in DATA_RD with TX_VALID=0, then resumes. Same bytes as T1.
// - T5: rst pulsed during the payload of T1.
//   - Outputs go to reset values asynchronously. The next INFO word produces a fresh A5-led frame.
// - T6: two INFO words queued (LEN 1: AB; LEN 2: 11,22), macro on.
//   - Two complete back-to-back frames. Second INFO_re occurs only after the first CSUM handshake.

Source files
------------

// File: rtl/usb_frame_serializer_if.sv
// FIFO-side and UART-side signal bundle of the USB frame serializer.
interface usb_frame_serializer_if;
    logic        INFO_buff_empty;
    logic [15:0] USB_INFO_DATA;
    logic        INFO_re;
    logic        DATA_buff_empty;
    logic [7:0]  USB_DATA;
    logic        DATA_re;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY;
    logic        BUSY;

    modport master (
        input  INFO_buff_empty, USB_INFO_DATA, DATA_buff_empty, USB_DATA, TX_READY,
        output INFO_re, DATA_re, TX_DATA, TX_VALID, BUSY
    );

    modport slave (
        output INFO_buff_empty, USB_INFO_DATA, DATA_buff_empty, USB_DATA, TX_READY,
        input  INFO_re, DATA_re, TX_DATA, TX_VALID, BUSY
    );
endinterface

// File: rtl/usb_frame_serializer.sv
// Turns captured USB packets (INFO word + payload FIFO) into SYNC/HDR/payload frames for UART TX.
// Define USB_FRAME_CSUM_EN to append an XOR checksum byte (HDR0, HDR1, payload) to every frame.
module usb_frame_serializer #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter logic [9:0] MAX_LEN   = 10'd1023
) (
    input  logic                    clk_ice,
    input  logic                    rst,
    usb_frame_serializer_if.master  bus
);

    typedef enum logic [3:0] {
        IDLE,
        INFO_WAIT,
        SYNC,
        HDR0,
        HDR1,
        DATA_RD,
        DATA_WAIT,
        DATA_TX
`ifdef USB_FRAME_CSUM_EN
        , CSUM
`endif
    } state_t;

    state_t      state_q, state_d;
    logic        info_re_q, info_re_d;
    logic        data_re_q, data_re_d;
    logic        tx_valid_q, tx_valid_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [9:0]  byte_cnt_q, byte_cnt_d;
    logic [5:0]  rxcmd_q, rxcmd_d;
    logic [9:0]  len_q, len_d;
    logic        hs;
    logic        last_byte;
`ifdef USB_FRAME_CSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

    function automatic logic [9:0] clamp_len(input logic [9:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

    assign hs = tx_valid_q & bus.TX_READY;

    always_comb begin
        state_d    = state_q;
        info_re_d  = 1'b0;
        data_re_d  = 1'b0;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        byte_cnt_d = byte_cnt_q;
        rxcmd_d    = rxcmd_q;
        len_d      = len_q;
        last_byte  = 1'b0;
`ifdef USB_FRAME_CSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (!bus.INFO_buff_empty) begin
                    info_re_d = 1'b1;
                    state_d   = INFO_WAIT;
                end
            end
            // First INFO_WAIT cycle carries the pop; the word is readable on the second.
            INFO_WAIT: begin
                if (!info_re_q) begin
                    rxcmd_d    = bus.USB_INFO_DATA[15:10];
                    len_d      = clamp_len(bus.USB_INFO_DATA[9:0]);
                    byte_cnt_d = 10'd0;
                    tx_data_d  = SYNC_BYTE;
                    tx_valid_d = 1'b1;
                    state_d    = SYNC;
`ifdef USB_FRAME_CSUM_EN
                    csum_d     = 8'h00;
`endif
                end
            end
            SYNC: begin
                if (hs) begin
                    tx_data_d = {rxcmd_q, len_q[9:8]};
                    state_d   = HDR0;
                end
            end
            HDR0: begin
                if (hs) begin
                    tx_data_d = len_q[7:0];
                    state_d   = HDR1;
                end
            end
            HDR1: begin
                if (hs) begin
                    if (len_q == 10'd0) begin
                        last_byte = 1'b1;
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = DATA_RD;
                    end
                end
            end
            DATA_RD: begin
                if (!bus.DATA_buff_empty) begin
                    data_re_d = 1'b1;
                    state_d   = DATA_WAIT;
                end
            end
            DATA_WAIT: begin
                if (!data_re_q) begin
                    tx_data_d  = bus.USB_DATA;
                    tx_valid_d = 1'b1;
                    state_d    = DATA_TX;
                end
            end
            DATA_TX: begin
                if (hs) begin
                    byte_cnt_d = byte_cnt_q + 10'd1;
                    if (byte_cnt_d == len_q) begin
                        last_byte = 1'b1;
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = DATA_RD;
                    end
                end
            end
`ifdef USB_FRAME_CSUM_EN
            CSUM: begin
                if (hs) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
`endif
            default: begin
                tx_valid_d = 1'b0;
                state_d    = IDLE;
            end
        endcase

`ifdef USB_FRAME_CSUM_EN
        if (hs && (state_q == HDR0 || state_q == HDR1 || state_q == DATA_TX)) begin
            csum_d = csum_q ^ tx_data_q;
        end
`endif
        // The frame's final data/header byte has just been accepted.
        if (last_byte) begin
`ifdef USB_FRAME_CSUM_EN
            tx_data_d  = csum_d;
            state_d    = CSUM;
`else
            tx_valid_d = 1'b0;
            state_d    = IDLE;
`endif
        end
    end

    always_ff @(posedge clk_ice or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            info_re_q  <= 1'b0;
            data_re_q  <= 1'b0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            byte_cnt_q <= 10'd0;
        end else begin
            state_q    <= state_d;
            info_re_q  <= info_re_d;
            data_re_q  <= data_re_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    // Packet descriptor and checksum are reloaded at every frame start.
    always_ff @(posedge clk_ice) begin
        rxcmd_q <= rxcmd_d;
        len_q   <= len_d;
`ifdef USB_FRAME_CSUM_EN
        csum_q  <= csum_d;
`endif
    end

    assign bus.INFO_re  = info_re_q;
    assign bus.DATA_re  = data_re_q;
    assign bus.TX_VALID = tx_valid_q;
    assign bus.TX_DATA  = tx_data_q;
    assign bus.BUSY     = (state_q != IDLE);

endmodule

// File: tb/tb_usb_frame_serializer.sv
// Directed bench for usb_frame_serializer: FIFO models, UART sink and per-scenario checks.
`timescale 1ns/1ps
module tb_usb_frame_serializer;

`ifdef USB_FRAME_CSUM_EN
    localparam bit CSUM_ON = 1'b1;
`else
    localparam bit CSUM_ON = 1'b0;
`endif

    logic clk_ice = 1'b0;
    logic rst     = 1'b1;
    always #5 clk_ice = ~clk_ice;

    int n_checks = 0;
    int n_err    = 0;

    usb_frame_serializer_if bif();
    usb_frame_serializer_if bif2();

    usb_frame_serializer dut (
        .clk_ice (clk_ice),
        .rst     (rst),
        .bus     (bif)
    );

    usb_frame_serializer #(.SYNC_BYTE(8'hA5), .MAX_LEN(10'd2)) dut2 (
        .clk_ice (clk_ice),
        .rst     (rst),
        .bus     (bif2)
    );

    // FIFO models for the main DUT; reset stands in for the integrator's flush.
    logic [15:0] info_mem [$];
    logic [7:0]  data_mem [$];
    int          info_wr = 0, info_rd = 0, info_pops = 0;
    int          data_wr = 0, data_rd = 0, data_pops = 0;
    logic        data_hold = 1'b0;

    assign bif.INFO_buff_empty = (info_rd == info_wr);
    assign bif.DATA_buff_empty = (data_rd == data_wr) || data_hold;

    always @(posedge clk_ice or posedge rst) begin
        if (rst) begin
            info_rd <= info_wr;
            data_rd <= data_wr;
        end else begin
            if (bif.INFO_re && (info_rd != info_wr)) begin
                bif.USB_INFO_DATA <= info_mem[info_rd];
                info_rd           <= info_rd + 1;
                info_pops         <= info_pops + 1;
            end
            if (bif.DATA_re && (data_rd != data_wr)) begin
                bif.USB_DATA <= data_mem[data_rd];
                data_rd      <= data_rd + 1;
                data_pops    <= data_pops + 1;
            end
        end
    end

    logic ready_toggle = 1'b0;
    logic ready_lvl    = 1'b1;
    int   phase        = 0;
    always @(posedge clk_ice) phase <= (phase == 2) ? 0 : phase + 1;
    assign bif.TX_READY = ready_toggle ? (phase == 0) : ready_lvl;

    // UART sink: records accepted bytes, INFO pops and hold-stability violations.
    logic [7:0] cap_q [$];
    int         cap_cyc [$];
    int         ire_cyc [$];
    int         cyc = 0, stab_err = 0, stall_n = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always @(negedge clk_ice) begin
        cyc <= cyc + 1;
        if (!rst) begin
            if (bif.TX_VALID && bif.TX_READY) begin
                cap_q.push_back(bif.TX_DATA);
                cap_cyc.push_back(cyc);
            end
            if (bif.INFO_re) ire_cyc.push_back(cyc);
            if (prev_stall && (!bif.TX_VALID || bif.TX_DATA != prev_data)) stab_err <= stab_err + 1;
            if (bif.TX_VALID && !bif.TX_READY) stall_n <= stall_n + 1;
        end
        prev_stall <= bif.TX_VALID && !bif.TX_READY && !rst;
        prev_data  <= bif.TX_DATA;
    end

    // Second DUT with MAX_LEN=2: one INFO word claiming LEN=3, endless payload source.
    logic       info2_go = 1'b0;
    logic       info2_popped = 1'b0;
    int         data2_pops = 0;
    logic [7:0] cap2_q [$];

    assign bif2.INFO_buff_empty = !(info2_go && !info2_popped);
    assign bif2.USB_INFO_DATA   = 16'b000111_0000000011;
    assign bif2.DATA_buff_empty = 1'b0;
    assign bif2.TX_READY        = 1'b1;

    always @(posedge clk_ice) begin
        if (bif2.INFO_re) info2_popped <= 1'b1;
        if (bif2.DATA_re) begin
            bif2.USB_DATA <= 8'h10 + data2_pops[7:0];
            data2_pops    <= data2_pops + 1;
        end
    end

    always @(negedge clk_ice) begin
        if (!rst && bif2.TX_VALID && bif2.TX_READY) cap2_q.push_back(bif2.TX_DATA);
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic push_info(input logic [15:0] w);
        info_mem.push_back(w);
        info_wr = info_wr + 1;
    endtask

    task automatic push_data(input logic [7:0] b);
        data_mem.push_back(b);
        data_wr = data_wr + 1;
    endtask

    task automatic wait_cap(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk_ice);
            #1;
            if (cap_q.size() >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(posedge clk_ice);
            #1;
            if (!bif.BUSY) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit ok;
        rst = 1'b1;
        repeat (3) @(posedge clk_ice);
        #1;
        n_checks++;
        if ({bif.INFO_re, bif.DATA_re, bif.TX_VALID, bif.BUSY} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctrl got=%b exp=0000", {bif.INFO_re, bif.DATA_re, bif.TX_VALID, bif.BUSY});
        end
        n_checks++;
        if (bif.TX_DATA !== 8'h00) begin
            n_err++;
            $display("FAIL reset_txdata got=%h exp=00", bif.TX_DATA);
        end
        @(negedge clk_ice);
        rst = 1'b0;
        wait_idle(3, ok);
        n_checks++;
        if (ok !== 1'b1 || bif.INFO_re !== 1'b0) begin
            n_err++;
            $display("FAIL reset_idle got busy=%b info_re=%b exp busy=0 info_re=0", bif.BUSY, bif.INFO_re);
        end
    endtask

    task automatic test_single_frame();
        logic [7:0] exp [$];
        int base, ib, db;
        bit ok;
        exp = '{8'hA5, 8'hB4, 8'h03, 8'hA4, 8'h3F, 8'h03};
        if (CSUM_ON) exp.push_back(8'h2F);
        @(posedge clk_ice);
        #1;
        base = cap_q.size(); ib = info_pops; db = data_pops;
        push_data(8'hA4); push_data(8'h3F); push_data(8'h03);
        push_info(16'b101101_0000000011);
        @(posedge clk_ice);
        #1;
        n_checks++;
        if (bif.INFO_re !== 1'b1) begin
            n_err++;
            $display("FAIL t1_info_re_latency got=%b exp=1", bif.INFO_re);
        end
        @(posedge clk_ice);
        #1;
        n_checks++;
        if (bif.INFO_re !== 1'b0) begin
            n_err++;
            $display("FAIL t1_info_re_pulse got=%b exp=0", bif.INFO_re);
        end
        @(posedge clk_ice);
        #1;
        n_checks++;
        if ({bif.TX_VALID, bif.TX_DATA} !== {1'b1, 8'hA5}) begin
            n_err++;
            $display("FAIL t1_sync_latency got vld=%b data=%h exp vld=1 data=a5", bif.TX_VALID, bif.TX_DATA);
        end
        wait_cap(base + exp.size(), 100, ok);
        wait_idle(20, ok);
        n_checks++;
        if (ok !== 1'b1 || cap_q.size() - base !== exp.size()) begin
            n_err++;
            $display("FAIL t1_len got=%0d exp=%0d idle=%b", cap_q.size() - base, exp.size(), ok);
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_checks++;
            if (base + i >= cap_q.size() || cap_q[base + i] !== exp[i]) begin
                n_err++;
                $display("FAIL t1_byte%0d got=%h exp=%h", i, (base + i < cap_q.size()) ? cap_q[base + i] : 8'hxx, exp[i]);
            end
        end
        n_checks++;
        if (info_pops - ib !== 1 || data_pops - db !== 3) begin
            n_err++;
            $display("FAIL t1_pops got info=%0d data=%0d exp info=1 data=3", info_pops - ib, data_pops - db);
        end
    endtask

    task automatic test_zero_len();
        logic [7:0] exp [$];
        int base, db;
        bit ok;
        exp = '{8'hA5, 8'h94, 8'h00};
        if (CSUM_ON) exp.push_back(8'h94);
        @(posedge clk_ice);
        #1;
        base = cap_q.size(); db = data_pops;
        push_info(16'b100101_0000000000);
        wait_cap(base + 3, 50, ok);
        @(posedge clk_ice);
        #1;
        n_checks++;
        if (ok !== 1'b1 || bif.BUSY !== CSUM_ON) begin
            n_err++;
            $display("FAIL t2_busy_after_hdr1 got=%b exp=%b reached=%b", bif.BUSY, CSUM_ON, ok);
        end
        wait_idle(20, ok);
        n_checks++;
        if (ok !== 1'b1 || cap_q.size() - base !== exp.size()) begin
            n_err++;
            $display("FAIL t2_len got=%0d exp=%0d idle=%b", cap_q.size() - base, exp.size(), ok);
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_checks++;
            if (base + i >= cap_q.size() || cap_q[base + i] !== exp[i]) begin
                n_err++;
                $display("FAIL t2_byte%0d got=%h exp=%h", i, (base + i < cap_q.size()) ? cap_q[base + i] : 8'hxx, exp[i]);
            end
        end
        n_checks++;
        if (data_pops - db !== 0) begin
            n_err++;
            $display("FAIL t2_no_data_re got=%0d exp=0", data_pops - db);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp [$];
        int base, se, sn;
        bit ok;
        exp = '{8'hA5, 8'hB4, 8'h03, 8'hA4, 8'h3F, 8'h03};
        if (CSUM_ON) exp.push_back(8'h2F);
        @(posedge clk_ice);
        #1;
        base = cap_q.size(); se = stab_err; sn = stall_n;
        ready_toggle = 1'b1;
        push_data(8'hA4); push_data(8'h3F); push_data(8'h03);
        push_info(16'b101101_0000000011);
        wait_cap(base + exp.size(), 300, ok);
        wait_idle(30, ok);
        ready_toggle = 1'b0;
        n_checks++;
        if (ok !== 1'b1 || cap_q.size() - base !== exp.size()) begin
            n_err++;
            $display("FAIL t3_len got=%0d exp=%0d idle=%b", cap_q.size() - base, exp.size(), ok);
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_checks++;
            if (base + i >= cap_q.size() || cap_q[base + i] !== exp[i]) begin
                n_err++;
                $display("FAIL t3_byte%0d got=%h exp=%h", i, (base + i < cap_q.size()) ? cap_q[base + i] : 8'hxx, exp[i]);
            end
        end
        n_checks++;
        if (stab_err - se !== 0 || stall_n - sn < 1) begin
            n_err++;
            $display("FAIL t3_hold_stable got violations=%0d stalls=%0d exp violations=0 stalls>0", stab_err - se, stall_n - sn);
        end
    endtask

    task automatic test_data_stall();
        logic [7:0] exp [$];
        int base, db, viol;
        bit ok;
        exp = '{8'hA5, 8'hB4, 8'h03, 8'hA4, 8'h3F, 8'h03};
        if (CSUM_ON) exp.push_back(8'h2F);
        @(posedge clk_ice);
        #1;
        base = cap_q.size(); db = data_pops;
        push_data(8'hA4); push_data(8'h3F); push_data(8'h03);
        push_info(16'b101101_0000000011);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(posedge clk_ice);
            #1;
            if (data_pops > db) begin
                ok = 1'b1;
                break;
            end
        end
        data_hold = 1'b1;
        viol = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk_ice);
            #1;
            if (k >= 2 && (bif.TX_VALID || bif.DATA_re || !bif.BUSY)) viol++;
        end
        n_checks++;
        if (ok !== 1'b1 || viol !== 0) begin
            n_err++;
            $display("FAIL t4_stall got first_pop=%b bad_cycles=%0d exp first_pop=1 bad_cycles=0", ok, viol);
        end
        data_hold = 1'b0;
        wait_cap(base + exp.size(), 100, ok);
        wait_idle(20, ok);
        n_checks++;
        if (ok !== 1'b1 || cap_q.size() - base !== exp.size()) begin
            n_err++;
            $display("FAIL t4_len got=%0d exp=%0d idle=%b", cap_q.size() - base, exp.size(), ok);
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_checks++;
            if (base + i >= cap_q.size() || cap_q[base + i] !== exp[i]) begin
                n_err++;
                $display("FAIL t4_byte%0d got=%h exp=%h", i, (base + i < cap_q.size()) ? cap_q[base + i] : 8'hxx, exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] exp [$];
        int base, ib, db;
        bit ok;
        exp = '{8'hA5, 8'h0C, 8'h01, 8'h5A};
        if (CSUM_ON) exp.push_back(8'h57);
        @(posedge clk_ice);
        #1;
        base = cap_q.size();
        push_data(8'hA4); push_data(8'h3F); push_data(8'h03);
        push_info(16'b101101_0000000011);
        wait_cap(base + 4, 100, ok);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (ok !== 1'b1 || {bif.INFO_re, bif.DATA_re, bif.TX_VALID, bif.BUSY, bif.TX_DATA} !== 12'h000) begin
            n_err++;
            $display("FAIL t5_async_reset got re=%b dre=%b vld=%b busy=%b data=%h exp all zero reached=%b",
                     bif.INFO_re, bif.DATA_re, bif.TX_VALID, bif.BUSY, bif.TX_DATA, ok);
        end
        repeat (2) @(negedge clk_ice);
        rst = 1'b0;
        @(posedge clk_ice);
        #1;
        base = cap_q.size(); ib = info_pops; db = data_pops;
        push_data(8'h5A);
        push_info(16'b000011_0000000001);
        wait_cap(base + exp.size(), 100, ok);
        wait_idle(20, ok);
        n_checks++;
        if (ok !== 1'b1 || cap_q.size() - base !== exp.size()) begin
            n_err++;
            $display("FAIL t5_len got=%0d exp=%0d idle=%b", cap_q.size() - base, exp.size(), ok);
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_checks++;
            if (base + i >= cap_q.size() || cap_q[base + i] !== exp[i]) begin
                n_err++;
                $display("FAIL t5_byte%0d got=%h exp=%h", i, (base + i < cap_q.size()) ? cap_q[base + i] : 8'hxx, exp[i]);
            end
        end
        n_checks++;
        if (info_pops - ib !== 1 || data_pops - db !== 1) begin
            n_err++;
            $display("FAIL t5_pops got info=%0d data=%0d exp info=1 data=1", info_pops - ib, data_pops - db);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp [$];
        int base, ib, db, ire0, f1;
        bit ok;
        exp = '{8'hA5, 8'h04, 8'h01, 8'hAB};
        if (CSUM_ON) exp.push_back(8'hAE);
        f1 = exp.size();
        exp.push_back(8'hA5); exp.push_back(8'h08); exp.push_back(8'h02);
        exp.push_back(8'h11); exp.push_back(8'h22);
        if (CSUM_ON) exp.push_back(8'h39);
        @(posedge clk_ice);
        #1;
        base = cap_q.size(); ib = info_pops; db = data_pops; ire0 = ire_cyc.size();
        push_data(8'hAB); push_data(8'h11); push_data(8'h22);
        push_info(16'b000001_0000000001);
        push_info(16'b000010_0000000010);
        wait_cap(base + exp.size(), 200, ok);
        wait_idle(20, ok);
        n_checks++;
        if (ok !== 1'b1 || cap_q.size() - base !== exp.size()) begin
            n_err++;
            $display("FAIL t6_len got=%0d exp=%0d idle=%b", cap_q.size() - base, exp.size(), ok);
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_checks++;
            if (base + i >= cap_q.size() || cap_q[base + i] !== exp[i]) begin
                n_err++;
                $display("FAIL t6_byte%0d got=%h exp=%h", i, (base + i < cap_q.size()) ? cap_q[base + i] : 8'hxx, exp[i]);
            end
        end
        n_checks++;
        if (ire_cyc.size() - ire0 !== 2 || info_pops - ib !== 2 || data_pops - db !== 3) begin
            n_err++;
            $display("FAIL t6_pops got info_re=%0d info=%0d data=%0d exp 2 2 3", ire_cyc.size() - ire0, info_pops - ib, data_pops - db);
        end
        n_checks++;
        if (ire_cyc.size() - ire0 < 2 || cap_q.size() < base + f1 || ire_cyc[ire0 + 1] <= cap_cyc[base + f1 - 1]) begin
            n_err++;
            $display("FAIL t6_second_info_re_early got cyc=%0d exp after cyc=%0d",
                     (ire_cyc.size() - ire0 >= 2) ? ire_cyc[ire0 + 1] : -1,
                     (cap_q.size() >= base + f1) ? cap_cyc[base + f1 - 1] : -1);
        end
    endtask

    task automatic test_max_len();
        logic [7:0] exp [$];
        bit ok;
        exp = '{8'hA5, 8'h1C, 8'h02, 8'h10, 8'h11};
        if (CSUM_ON) exp.push_back(8'h1F);
        info2_go = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk_ice);
            #1;
            if (cap2_q.size() >= exp.size() && !bif2.BUSY) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (5) @(posedge clk_ice);
        #1;
        n_checks++;
        if (ok !== 1'b1 || cap2_q.size() !== exp.size()) begin
            n_err++;
            $display("FAIL maxlen_len got=%0d exp=%0d done=%b", cap2_q.size(), exp.size(), ok);
        end
        for (int i = 0; i < exp.size(); i++) begin
            n_checks++;
            if (i >= cap2_q.size() || cap2_q[i] !== exp[i]) begin
                n_err++;
                $display("FAIL maxlen_byte%0d got=%h exp=%h", i, (i < cap2_q.size()) ? cap2_q[i] : 8'hxx, exp[i]);
            end
        end
        n_checks++;
        if (data2_pops !== 2) begin
            n_err++;
            $display("FAIL maxlen_pops got=%0d exp=2", data2_pops);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_zero_len();
        test_backpressure();
        test_data_stall();
        test_reset_mid_frame();
        test_back_to_back();
        test_max_len();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
